divider_constant_time: RTL and testbench
========================================

# divider_constant_time

Sequential unsigned restoring divider, the inverse datapath companion to the team's constant-time shift-add multiplier. It takes a NUM_BITS dividend and divisor on a `start` pulse and produces quotient and remainder in a fixed number of cycles, independent of operand values, including divide-by-zero. It shares the multiplier's control style (`start` pulse, registered result held until the next completion), so both can sit side by side in the arithmetic unit.

## Interface
- NUM_BITS, 7, operand and result width (≥2)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  request; sampled only while idle
- dividend  input  NUM_BITS  unsigned dividend, sampled with start
- divisor  input  NUM_BITS  unsigned divisor, sampled with start
- quotient  output  NUM_BITS  registered quotient of last completed operation
- remainder  output  NUM_BITS  registered remainder of last completed operation
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse on result update

## Operation
- States: IDLE, RUN.
- IDLE: on a clk edge with start=1, latch dividend into the quotient shift register Q and divisor into D. Clear the partial remainder R (NUM_BITS+1 bits) and the iteration counter. Go to RUN with busy=1. If start=0, hold.
- RUN, one iteration per edge, NUM_BITS iterations:
  - T = {R[NUM_BITS-1:0], Q[NUM_BITS-1]}; Q shifts left.
  - If T ≥ {1'b0, D}: R = T − D and Q[0] = 1. Otherwise R = T and Q[0] = 0.
  - The compare and subtract run every iteration regardless of operands. No early exit.
- On the last iteration:
  - Write quotient ← final Q and remainder ← final R[NUM_BITS-1:0].
  - Assert done for exactly one cycle, drop busy, return to IDLE.
- Divisor = 0: no special-casing. The algorithm naturally yields quotient = all ones (2^NUM_BITS−1) and remainder = dividend, with the same latency.
- start while busy: ignored. Inputs may change freely during RUN without effect.
- quotient/remainder hold their value from the previous completion until the next one. They never show intermediate values.
- Invariant for divisor ≠ 0: dividend = quotient·divisor + remainder, with remainder < divisor.

## Timing
- Reset (rst=0, async): state=IDLE, busy=0, done=0, quotient=0, remainder=0, internal Q/R/D/counter=0. Takes effect immediately without a clock edge.
- Reset mid-operation: aborts the operation, discards partial results, forces the reset values above. First start accepted on the first edge after rst returns high.
- Start accepted at edge E0. busy=1 from E0 until EN.
- Iterations occur at edges E1..EN (N = NUM_BITS).
- At EN: results written, done=1, busy=0. Latency from start edge to done is exactly NUM_BITS cycles for all operands.
- done drops at EN+1 unless a new operation completes there, which is impossible.
- Back-to-back: start high during the done cycle is accepted at EN+1, since the block is in IDLE. Sustained throughput is one result per NUM_BITS+1 cycles.
- start held high continuously: a new operation begins at each IDLE edge. No edge detection.

## Test plan
- Reset, then 100 / 7 (NUM_BITS=7), start for one edge -> busy high 7 cycles, done pulses one cycle at 7th edge, quotient=14, remainder=2. Outputs before done remain 0.
- 0 / 12, then 127 / 1 -> quotient=0/remainder=0, then quotient=127/remainder=0. done at exactly 7 edges each.
- 92 / 0 -> quotient=127, remainder=92, done at 7 edges (same latency as nonzero divisor).
- Start 92 / 75, toggle start and change dividend/divisor mid-RUN -> quotient=1, remainder=17, single done pulse. Assert start during done cycle with 75 / 92 -> accepted, next result quotient=0, remainder=75, 7 edges later.
- Start 100 / 7, assert rst=0 between clock edges after 3 iterations -> busy, done, quotient, remainder go to 0 immediately. Release rst, start 6 / 3 -> quotient=2, remainder=0 after 7 edges.
- Random sweep (≥500 operand pairs, divisor ≠ 0) -> invariant dividend = q·d + r with r < d holds. done latency always 7.

Source files
------------

// File: rtl/divider_constant_time_if.sv
// Request/result bundle for the constant-time restoring divider.
interface divider_constant_time_if #(
  parameter int NUM_BITS = 7
);
  logic                start;
  logic [NUM_BITS-1:0] dividend;
  logic [NUM_BITS-1:0] divisor;
  logic [NUM_BITS-1:0] quotient;
  logic [NUM_BITS-1:0] remainder;
  logic                busy;
  logic                done;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done
  );
endinterface

// File: rtl/divider_constant_time.sv
// Sequential unsigned restoring divider. The latency is NUM_BITS cycles for
// every operand pair, divide-by-zero included. Compare and subtract run on
// every iteration, so timing never depends on the data.
module divider_constant_time #(
  parameter int NUM_BITS = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  divider_constant_time_if.slave  bus
);

  localparam int CW = $clog2(NUM_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]          state;
  logic [NUM_BITS-1:0] q;      // dividend shifting out, quotient bits shifting in
  logic [NUM_BITS-1:0] d;
  logic [NUM_BITS:0]   r;      // partial remainder, one guard bit
  logic [CW-1:0]       cnt;

  logic [NUM_BITS:0]   t;
  logic                ge;
  logic [NUM_BITS:0]   r_nxt;
  logic [NUM_BITS-1:0] q_nxt;

  // One restoring step: shift in the next dividend bit, then trial-subtract.
  always_comb begin
    t     = {r[NUM_BITS-1:0], q[NUM_BITS-1]};
    ge    = (t >= {1'b0, d});
    r_nxt = ge ? (t - {1'b0, d}) : t;
    q_nxt = {q[NUM_BITS-2:0], ge};
  end

  // Control and datapath. Results update only on the final iteration, so the
  // outputs never show partial values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      q             <= '0;
      d             <= '0;
      r             <= '0;
      cnt           <= '0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            q        <= bus.dividend;
            d        <= bus.divisor;
            r        <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= S_RUN;
          end
        end
        default: begin
          q   <= q_nxt;
          r   <= r_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            bus.quotient  <= q_nxt;
            bus.remainder <= r_nxt[NUM_BITS-1:0];
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_constant_time.sv
// Scoreboard bench for divider_constant_time (NUM_BITS = 7).
module tb_divider_constant_time;

  localparam int NB = 7;

  typedef struct {
    logic [NB-1:0] q;
    logic [NB-1:0] r;
    int            e0;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  exp_t sb[$];
  logic [NB-1:0] hq;
  logic [NB-1:0] hr;

  divider_constant_time_if #(.NUM_BITS(NB)) bus ();

  divider_constant_time #(.NUM_BITS(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Drive one request at the current negedge and record what it must return.
  task automatic issue(input int a, input int b, input int qe, input int re);
    exp_t e;
    bus.start    = 1'b1;
    bus.dividend = NB'(a);
    bus.divisor  = NB'(b);
    e.q  = NB'(qe);
    e.r  = NB'(re);
    e.e0 = cyc + 1;
    sb.push_back(e);
  endtask

  // Single operation; returns at the negedge of the done cycle.
  task automatic op(input int a, input int b, input int qe, input int re);
    @(negedge clk);
    issue(a, b, qe, re);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  // Monitor: checks results on done, held outputs and busy otherwise.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_unexpected: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", int'(bus.quotient), int'(e.q));
          chk("remainder", int'(bus.remainder), int'(e.r));
          chk("latency", cyc - e.e0, 7);
          chk("busy_at_done", int'(bus.busy), 0);
          hq = e.q;
          hr = e.r;
        end
      end else begin
        chk("held_quotient", int'(bus.quotient), int'(hq));
        chk("held_remainder", int'(bus.remainder), int'(hr));
        chk("busy", int'(bus.busy), int'(sb.size() > 0 && cyc >= sb[0].e0));
        if (sb.size() > 0 && cyc > sb[0].e0 + 7) begin
          total++;
          bad++;
          $display("FAIL done_timeout: got no done expected done by cycle %0d (cycle %0d)",
                   sb[0].e0 + 7, cyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    hq    = '0;
    hr    = '0;
    rst   = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    repeat (3) @(negedge clk);
    chk("rst_quotient", int'(bus.quotient), 0);
    chk("rst_remainder", int'(bus.remainder), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    #1 rst = 1'b1;

    op(100, 7, 14, 2);
    op(0, 12, 0, 0);
    op(127, 1, 127, 0);
    op(92, 0, 127, 92);
    op(1, 127, 0, 1);

    // Inputs and start wiggle during RUN; then back-to-back from the done cycle.
    @(negedge clk);
    issue(92, 75, 1, 17);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.start    = ~bus.start;
      bus.dividend = NB'($urandom);
      bus.divisor  = NB'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    issue(75, 92, 0, 75);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);

    // Asynchronous reset after three iterations.
    @(negedge clk);
    issue(100, 7, 14, 2);
    repeat (4) @(negedge clk);
    bus.start = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_quotient", int'(bus.quotient), 0);
    chk("midrst_remainder", int'(bus.remainder), 0);
    sb.delete();
    hq = '0;
    hr = '0;
    @(negedge clk);
    #1 rst = 1'b1;
    op(6, 3, 2, 0);

    for (int i = 0; i < 500; i++) begin
      int a;
      int b;
      a = int'($urandom_range(0, 127));
      b = int'($urandom_range(1, 127));
      op(a, b, a / b, a % b);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
